// File: rtl/i2c_trace_buffer_pkg.sv
// Shared types and helpers for the I2C trace buffer: entry type codes,
// entry field positions, decoder state encodings and an entry packer.
package i2c_trace_pkg;

    typedef enum logic [1:0] {
        TRC_START     = 2'b00,
        TRC_STOP      = 2'b01,
        TRC_BYTE_ACK  = 2'b10,
        TRC_BYTE_NACK = 2'b11
    } trc_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BITS = 2'b01,
        ACK  = 2'b10
    } dec_state_e;

    localparam int unsigned ENT_WIDTH    = 32;
    localparam int unsigned ENT_TYPE_LSB = 30;
    localparam int unsigned ENT_DATA_LSB = 16;
    localparam int unsigned ENT_TS_LSB   = 0;

    // Pack one log entry; bits [29:24] are always zero.
    function automatic logic [ENT_WIDTH-1:0] trc_make_entry(
        input trc_type_e   kind,
        input logic [7:0]  data,
        input logic [15:0] ts
    );
        logic [ENT_WIDTH-1:0] ent;
        ent = 32'd0;
        ent[ENT_TYPE_LSB +: 2] = kind;
        ent[ENT_DATA_LSB +: 8] = data;
        ent[ENT_TS_LSB +: 16]  = ts;
        return ent;
    endfunction

endpackage

// File: rtl/i2c_trace_buffer_fifo.sv
// First-word-fall-through FIFO for trace entries. Pop is ignored when empty;
// push is accepted when not full or when a pop frees a slot in the same cycle.
// Clear has priority over push and pop.
module i2c_trace_fifo
    import i2c_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign count     = count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; unwritten slots are never visible because of the empty mux.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head entry presented directly from storage, forced to zero when empty.
    always_comb begin
        if (empty) begin
            rdata = '0;
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/i2c_trace_buffer.sv
// Passive I2C monitor: decodes START/STOP/byte events from synchronised
// SDA/SCL, timestamps them into a FWFT FIFO and pulses a match trigger.
module i2c_trace_buffer
    import i2c_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic                       i_sys_clk,
    input  logic                       i_rst_n,
    input  logic                       i_enable,
    input  logic                       i_clear,
    input  logic                       i_sda_in,
    input  logic                       i_scl_in,
    input  logic                       i_rd_en,
    input  logic                       i_match_en,
    input  logic [7:0]                 i_match_byte,
    output logic [31:0]                o_entry,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_trigger
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic        sda_q_r, scl_q_r;
    dec_state_e  state_r, state_n_s;
    logic [2:0]  bit_cnt_r, bit_cnt_n_s;
    logic [7:0]  data_r, data_n_s;
    logic [15:0] ts_r;
    logic [PW-1:0] pre_r;
    logic        overflow_r, trigger_r;
    logic        start_s, stop_s, rise_s;
    logic        log_s, byte_evt_s, push_s;
    logic [31:0] entry_s;
    logic        fifo_full_s, fifo_empty_s;

    assign start_s = scl_q_r & i_scl_in & sda_q_r & ~i_sda_in;
    assign stop_s  = scl_q_r & i_scl_in & ~sda_q_r & i_sda_in;
    assign rise_s  = ~scl_q_r & i_scl_in;
    // The decoder always runs; only storing the entry depends on enable.
    assign push_s  = log_s & i_enable;

    // Registered copies of the bus lines for edge detection.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sda_q_r <= 1'b1;
            scl_q_r <= 1'b1;
        end else begin
            sda_q_r <= i_sda_in;
            scl_q_r <= i_scl_in;
        end
    end

    // Decoder state register; clear deliberately leaves framing intact.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            data_r    <= 8'd0;
        end else begin
            state_r   <= state_n_s;
            bit_cnt_r <= bit_cnt_n_s;
            data_r    <= data_n_s;
        end
    end

    // Decoder next state and the entry to log this cycle.
    always_comb begin
        state_n_s   = state_r;
        bit_cnt_n_s = bit_cnt_r;
        data_n_s    = data_r;
        log_s       = 1'b0;
        byte_evt_s  = 1'b0;
        entry_s     = 32'd0;
        if (stop_s) begin
            state_n_s   = IDLE;
            bit_cnt_n_s = 3'd0;
            log_s       = 1'b1;
            entry_s     = trc_make_entry(TRC_STOP, 8'd0, ts_r);
        end else if (start_s) begin
            state_n_s   = BITS;
            bit_cnt_n_s = 3'd0;
            log_s       = 1'b1;
            entry_s     = trc_make_entry(TRC_START, 8'd0, ts_r);
        end else if (rise_s) begin
            case (state_r)
                IDLE: begin
                    state_n_s = IDLE;
                end
                BITS: begin
                    data_n_s    = {data_r[6:0], i_sda_in};
                    bit_cnt_n_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_n_s = ACK;
                    end else begin
                        state_n_s = BITS;
                    end
                end
                ACK: begin
                    state_n_s   = BITS;
                    bit_cnt_n_s = 3'd0;
                    log_s       = 1'b1;
                    byte_evt_s  = 1'b1;
                    if (i_sda_in) begin
                        entry_s = trc_make_entry(TRC_BYTE_NACK, data_r, ts_r);
                    end else begin
                        entry_s = trc_make_entry(TRC_BYTE_ACK, data_r, ts_r);
                    end
                end
                default: begin
                    state_n_s   = IDLE;
                    bit_cnt_n_s = 3'd0;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // Free-running timestamp with prescale divider; wraps silently.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_r  <= 16'd0;
            pre_r <= '0;
        end else if (i_clear) begin
            ts_r  <= 16'd0;
            pre_r <= '0;
        end else if (pre_r == PRE_LAST) begin
            ts_r  <= ts_r + 16'd1;
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PW'(1);
        end
    end

    // Sticky overflow: a push was refused because no slot was free.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_r <= 1'b0;
        end else if (i_clear) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s && !i_rd_en) begin
            overflow_r <= 1'b1;
        end
    end

    // Byte-match breakpoint pulse, independent of enable and FIFO state.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trigger_r <= 1'b0;
        end else begin
            trigger_r <= byte_evt_s & i_match_en & (data_r == i_match_byte);
        end
    end

    i2c_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (i_sys_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .push  (push_s),
        .pop   (i_rd_en),
        .wdata (entry_s),
        .rdata (o_entry),
        .count (o_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign o_valid    = ~fifo_empty_s;
    assign o_overflow = overflow_r;
    assign o_trigger  = trigger_r;

endmodule

// File: tb/tb_i2c_trace_buffer.sv
// Directed bench for i2c_trace_buffer: bus-level stimulus with expected
// entries built from a timestamp reference counter and a queue.
module tb_i2c_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n, enable, clear, sda, scl, rd_en, match_en;
    logic [7:0]  match_byte;
    logic [31:0] entry, entry4;
    logic        valid, valid4, ovf, ovf4, trig, trig4;
    logic [4:0]  count, count4;

    int          n_chk = 0;
    int          n_pass = 0;
    int          trig_pulses = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_ts;
    logic        m_ovf;

    always #5 clk = ~clk;

    i2c_trace_buffer #(.DEPTH(16), .PRESCALE(1)) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clear(clear),
        .i_sda_in(sda), .i_scl_in(scl), .i_rd_en(rd_en), .i_match_en(match_en),
        .i_match_byte(match_byte), .o_entry(entry), .o_valid(valid),
        .o_count(count), .o_overflow(ovf), .o_trigger(trig)
    );

    i2c_trace_buffer #(.DEPTH(16), .PRESCALE(4)) dut4 (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clear(clear),
        .i_sda_in(sda), .i_scl_in(scl), .i_rd_en(rd_en), .i_match_en(match_en),
        .i_match_byte(match_byte), .o_entry(entry4), .o_valid(valid4),
        .o_count(count4), .o_overflow(ovf4), .o_trigger(trig4)
    );

    // Reference timestamp for the PRESCALE=1 instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     m_ts <= 16'd0;
        else if (clear) m_ts <= 16'd0;
        else            m_ts <= m_ts + 16'd1;
    end

    // Count trigger pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (trig === 1'b1) trig_pulses <= trig_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
    endtask

    task automatic step();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic log_exp(input logic [1:0] kind, input logic [7:0] d);
        logic [31:0] e;
        e = {kind, 6'd0, d, m_ts};
        if (enable) begin
            if (exp_q.size() < 16) exp_q.push_back(e);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic bus_start();
        if (!scl) begin
            step(); sda = 1'b1;
            step(); scl = 1'b1;
        end
        step(); sda = 1'b0; log_exp(2'b00, 8'd0);
        step(); scl = 1'b0;
    endtask

    task automatic bus_stop();
        step(); sda = 1'b0;
        step(); scl = 1'b1;
        step(); sda = 1'b1; log_exp(2'b01, 8'd0);
    endtask

    task automatic send_bit(input logic b);
        step(); sda = b;
        step(); scl = 1'b1;
        step(); scl = 1'b0;
    endtask

    task automatic bus_byte(input logic [7:0] d, input logic nack, input logic exp_trig);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        step(); sda = nack;
        step(); scl = 1'b1; log_exp(nack ? 2'b11 : 2'b10, d);
        @(posedge clk); #1;
        chk("trigger", 32'(trig), 32'(exp_trig));
        chk("trigger_p4", 32'(trig4), 32'(exp_trig));
        step(); scl = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int n);
        logic [31:0] e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            chk(tag, entry, e);
            rd_en = 1'b1;
            @(posedge clk); #1;
            rd_en = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        pop_check(tag, exp_q.size());
        chk({tag, "_valid_end"}, 32'(valid), 32'd0);
        chk({tag, "_entry_end"}, entry, 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        int          p0;
        int          guard;
        logic [31:0] e, e4a, e4b;
        logic [15:0] d4;

        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; sda = 1'b1; scl = 1'b1;
        rd_en = 1'b0; match_en = 1'b0; match_byte = 8'h3C; m_ovf = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_entry", entry, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        rst_n = 1'b1; enable = 1'b1;

        // START, 0xA0 ACK, STOP
        bus_start(); bus_byte(8'hA0, 1'b0, 1'b0); bus_stop(); step();
        chk("t1_count", 32'(count), 32'd3);
        drain("t1_entry");
        chk("t1_count_end", 32'(count), 32'd0);

        // START, 0x5A NACK, repeated START, 0x5B ACK, STOP
        bus_start(); bus_byte(8'h5A, 1'b1, 1'b0);
        bus_start(); bus_byte(8'h5B, 1'b0, 1'b0); bus_stop(); step();
        chk("t2_count", 32'(count), 32'd5);
        drain("t2_entry");

        // Capture disabled; matching byte with match disabled gives no trigger
        enable = 1'b0;
        bus_start(); bus_byte(8'h3C, 1'b0, 1'b0); bus_stop(); step();
        chk("dis_count", 32'(count), 32'd0);
        enable = 1'b1;

        // STOP after 4 data bits: no byte entry
        bus_start(); repeat (4) send_bit(1'b1); bus_stop(); step();
        drain("partial_entry");

        // Byte match trigger
        match_en = 1'b1;
        p0 = trig_pulses;
        bus_start(); bus_byte(8'h12, 1'b0, 1'b0); bus_byte(8'h3C, 1'b0, 1'b1); bus_stop(); step();
        chk("trig_pulses", 32'(trig_pulses - p0), 32'd1);
        drain("trig_entry");
        match_en = 1'b0;

        // Fill to 16 entries
        for (int i = 0; i < 8; i++) begin bus_start(); bus_stop(); end
        step();
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf0", 32'(ovf), 32'd0);
        // Push and pop together while full
        step(); sda = 1'b0; rd_en = 1'b1;
        void'(exp_q.pop_front()); log_exp(2'b00, 8'd0);
        @(posedge clk); #1; rd_en = 1'b0;
        chk("pushpop_count", 32'(count), 32'd16);
        chk("pushpop_ovf", 32'(ovf), 32'd0);
        chk("pushpop_head", entry, exp_q[0]);
        step(); scl = 1'b0;
        bus_stop();
        for (int i = 0; i < 2; i++) begin bus_start(); bus_stop(); end
        // Trigger still fires with the FIFO full
        match_en = 1'b1;
        p0 = trig_pulses;
        bus_start(); bus_byte(8'h3C, 1'b0, 1'b1); bus_stop(); step();
        match_en = 1'b0;
        chk("full_trig_pulses", 32'(trig_pulses - p0), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'(m_ovf));
        pop_check("full_contents", 8);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        pulse_clear();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_entry", entry, 32'd0);
        chk("clr_valid", 32'(valid), 32'd0);

        // Reset mid-byte, then a full transaction
        bus_start(); repeat (3) send_bit(1'b0);
        step(); rst_n = 1'b0; exp_q.delete(); m_ovf = 1'b0;
        step();
        chk("midrst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        step(); sda = 1'b1;
        step(); scl = 1'b1;
        bus_start(); bus_byte(8'hC3, 1'b0, 1'b0); bus_stop(); step();
        chk("midrst_count2", 32'(count), 32'd3);
        drain("midrst_entry");

        // PRESCALE=4: START and STOP 400 clocks apart
        pulse_clear();
        step(); sda = 1'b0; log_exp(2'b00, 8'd0);
        repeat (400) @(posedge clk); #1;
        sda = 1'b1; log_exp(2'b01, 8'd0);
        step();
        chk("p4_count", 32'(count4), 32'd2);
        e4a = entry4;
        chk("p4_start_type", 32'(e4a[31:30]), 32'd0);
        e = exp_q.pop_front();
        chk("p1_start", entry, e);
        rd_en = 1'b1; @(posedge clk); #1; rd_en = 1'b0;
        e4b = entry4;
        chk("p4_stop_type", 32'(e4b[31:30]), 32'd1);
        d4 = e4b[15:0] - e4a[15:0];
        chk("p4_delta", 32'(d4), 32'd100);
        drain("p1_stop");
        chk("p4_valid_end", 32'(valid4), 32'd0);
        chk("p4_ovf", 32'(ovf4), 32'd0);

        // Timestamp wrap 0xFFFF -> 0x0000
        pulse_clear();
        guard = 0;
        while (m_ts != 16'hFFF8 && guard < 70000) begin
            @(posedge clk); #1;
            guard++;
        end
        bus_start(); bus_stop(); step();
        drain("wrap_entry");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_trace_buffer.md
Name: i2c_trace_buffer

Overview:
- Passive I2C bus monitor. Decodes START, STOP and byte/ACK events from the synchronised SDA/SCL lines and stores timestamped 32-bit entries in a FIFO.
- Sits beside the debug/test block and feeds its transaction-log register. Debug software pops entries one at a time through a read strobe.
- Also emits a one-cycle trigger when a logged byte matches a programmed value; the trigger is used as a breakpoint source.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- PRESCALE, 1: timestamp increments once every PRESCALE clocks; minimum 1.

Ports:
- i_sys_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  reset, asynchronous assert, active low.
- i_enable  in  1  capture enable; events seen while low are not logged.
- i_clear  in  1  synchronous flush: empties FIFO, clears overflow, zeroes timestamp.
- i_sda_in  in  1  SDA, already synchronised to i_sys_clk.
- i_scl_in  in  1  SCL, already synchronised to i_sys_clk.
- i_rd_en  in  1  pop head entry; ignored when empty.
- i_match_en  in  1  enable byte-match trigger.
- i_match_byte  in  8  byte value to match.
- o_entry  out  32  head entry, first-word-fall-through; 0 when empty.
- o_valid  out  1  FIFO not empty.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_overflow  out  1  sticky: an entry was dropped because the FIFO was full.
- o_trigger  out  1  one-cycle pulse on a matching byte.

Behaviour:
- Reset (async, i_rst_n low): FIFO empty, o_valid 0, o_count 0, o_entry 0, o_overflow 0, o_trigger 0, timestamp 0, decoder state IDLE, sda_q/scl_q = 1.
- Edge detection uses registered sda_q and scl_q:
  - START: scl_q & scl & sda_q & !sda.
  - STOP: scl_q & scl & !sda_q & sda.
  - SCL rise: !scl_q & scl.
  - These three are mutually exclusive by construction.
- Decoder FSM:
  - IDLE: START -> BITS, bit_cnt = 0.
  - BITS: each SCL rise shifts sda into data MSB-first and increments bit_cnt. The 8th rise goes to ACK.
  - ACK: SCL rise logs a byte entry (ACK if sda = 0, NACK if sda = 1), then -> BITS with bit_cnt = 0.
  - START in BITS or ACK is a repeated start: log START, -> BITS, bit_cnt = 0. The partial byte is discarded with no entry.
  - STOP in any state: log STOP, -> IDLE. A partial byte is discarded.
  - SCL rise in IDLE is ignored.
- Entry format:
  - [31:30] type: 00 START, 01 STOP, 10 BYTE_ACK, 11 BYTE_NACK.
  - [29:24] zero.
  - [23:16] data byte; zero for START/STOP.
  - [15:0] timestamp value in the detection cycle.
- Latency: the event is detected in cycle N (the cycle where the input differs from its registered copy). The push is registered at the end of N; o_valid, o_count and o_entry reflect it in N+1. o_trigger is high in N+1.
- The decoder runs regardless of i_enable; only the push is gated, so bus framing stays correct.
- Push when full without a pop: entry dropped, o_overflow set, FIFO contents unchanged.
- Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
- Push and pop in the same cycle when empty: push stored, pop ignored.
- Pop advances the head; o_entry shows the next entry in the following cycle.
- i_clear has priority over push and pop in the same cycle. It does not reset the decoder FSM.
- Timestamp: 16-bit free-running counter with a PRESCALE divider. Wraps 0xFFFF -> 0x0000 silently.
- Trigger: on a byte event with i_match_en = 1 and data == i_match_byte, o_trigger pulses. This is independent of i_enable and FIFO fullness.
- Asserting reset mid-byte returns the block to IDLE; the partial byte is never logged.

Decomposition:
- Package i2c_trace_pkg holds:
  - type codes TRC_START, TRC_STOP, TRC_BYTE_ACK, TRC_BYTE_NACK;
  - entry field bit positions;
  - decoder state encodings IDLE, BITS, ACK.
- One sub-module, i2c_trace_fifo: a synchronous FWFT FIFO with push/pop/clear, count and full/empty outputs.
- The decoder, timestamp and trigger logic stay in the top module.

Test Plan:
- Reset, enable, then drive START, 0xA0 with ACK, STOP -> three entries 0x0000_tttt, 0x80A0_tttt, 0x4000_tttt in order, with non-decreasing timestamps; o_count 3 -> 0 after three pops.
- START, 0x5A NACK, START (repeated), 0x5B ACK, STOP -> entries START, 0xC05A_tttt, START, 0x805B_tttt, STOP.
- DEPTH = 16: 20 events with no pops -> o_count 16, o_overflow 1, first 16 entries retained; i_clear -> o_count 0, o_overflow 0, o_entry 0.
- STOP after 4 data bits -> only START and STOP logged, no byte entry. A reset pulse mid-byte followed by a full transaction logs correctly.
- i_match_en = 1, i_match_byte = 0x3C: bus bytes 0x12, 0x3C -> exactly one o_trigger pulse, in the cycle after the 0x3C ACK-bit SCL rise. The pulse also occurs with the FIFO full.
- PRESCALE = 4: consecutive START/STOP 400 clocks apart -> timestamps differ by 100; the counter wraps from 0xFFFF to 0x0000 without error.
